// File: rtl/amem_pkg.sv
// A-memory port shared definitions.
// Geometry, FSM state type, read-source select and parity helper.
package amem_pkg;

   localparam int AW        = 10;
   localparam int DW        = 32;
   localparam int INIT_LAST = 2**AW - 1;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // Which register currently feeds the amem output.
   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_RAM,
      SRC_BYP
   } src_t;

   // Odd parity: data plus this bit always XORs to 1.
   function automatic logic par_of(logic [DW-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/amem_ram.sv
// A-memory storage array: one sync write port, one sync read port.
// No reset; contents are defined by the clear sweep.
module amem_ram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wadr,
   input  logic [DW:0]   wdat,
   input  logic          re,
   input  logic [AW-1:0] radr,
   output logic [DW:0]   rdat
);

   logic [DW:0] mem [2**AW];

   // Registered write and registered read.
   always_ff @(posedge clk) begin
      if (we) mem[wadr] <= wdat;
      if (re) rdat <= mem[radr];
   end

endmodule

// File: rtl/amem_port.sv
// A-memory port: clear sweep FSM, posted write, read bypass, parity.
// Array reads are registered; a source select picks RAM or bypass.
module amem_port
   import amem_pkg::*;
#(
   parameter int AW = amem_pkg::AW,
   parameter int DW = amem_pkg::DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] aadr,
   input  logic          arp,
   input  logic          awp,
   input  logic [DW-1:0] l,
   output logic [DW-1:0] amem,
   output logic          amem_perr,
   output logic          ready
);

   localparam logic [AW-1:0] LAST = AW'(INIT_LAST);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          pw_valid;
   logic [AW-1:0] pw_adr;
   logic [DW-1:0] pw_dat;
   src_t          src_q, src_d;
   logic [DW-1:0] byp_q, byp_d;
   logic          run, rd, wt, hit_pw;
   logic          we;
   logic [AW-1:0] wadr;
   logic [DW:0]   wdat;
   logic [DW:0]   ram_q;

   assign run    = (state_q == RUN);
   assign rd     = run & arp;
   // arp and awp share aadr, so a joint pulse is a same-address write-through.
   assign wt     = rd & awp;
   assign hit_pw = rd & pw_valid & (aadr == pw_adr);

   // Sweep counter advances in INIT, parks on the last address.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         INIT: begin
            if (cnt_q == LAST) state_d = RUN;
            else               cnt_d   = cnt_q + 1'b1;
         end
         RUN: ;
         default: state_d = INIT;
      endcase
   end

   // FSM state and sweep counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single posted-write slot; it commits on the following edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pw_valid <= 1'b0;
         pw_adr   <= '0;
         pw_dat   <= '0;
      end else begin
         pw_valid <= run & awp;
         if (run & awp) begin
            pw_adr <= aadr;
            pw_dat <= l;
         end
      end
   end

   // Array write: sweep zeros in INIT, posted write in RUN.
   always_comb begin
      we   = 1'b1;
      wadr = cnt_q;
      wdat = {par_of('0), {DW{1'b0}}};
      if (run) begin
         we   = pw_valid;
         wadr = pw_adr;
         wdat = {par_of(pw_dat), pw_dat};
      end
   end

   // Read source: newest data wins over the pending write, then the array.
   always_comb begin
      src_d = src_q;
      byp_d = byp_q;
      if (rd) begin
         if (wt | hit_pw) begin
            src_d = SRC_BYP;
            byp_d = wt ? l : pw_dat;
         end else begin
            src_d = SRC_RAM;
         end
      end
   end

   // Output source and bypass data hold between reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q <= SRC_ZERO;
         byp_q <= '0;
      end else begin
         src_q <= src_d;
         byp_q <= byp_d;
      end
   end

   amem_ram #(
      .AW(AW),
      .DW(DW)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .wadr (wadr),
      .wdat (wdat),
      .re   (rd),
      .radr (aadr),
      .rdat (ram_q)
   );

   // Output mux over registered sources; parity checked on array data only.
   always_comb begin
      amem      = '0;
      amem_perr = 1'b0;
      unique case (src_q)
         SRC_RAM: begin
            amem      = ram_q[DW-1:0];
            amem_perr = ~^ram_q;
         end
         SRC_BYP: amem = byp_q;
         default: ;
      endcase
   end

   assign ready = run;

endmodule

// File: tb/tb_amem_port.sv
// Self-checking bench for amem_port.
// Reference: flat word array where reads see all earlier and same-cycle writes.
module tb_amem_port;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  aadr = '0;
   logic        arp = 1'b0;
   logic        awp = 1'b0;
   logic [31:0] l = '0;
   logic [31:0] amem;
   logic        amem_perr;
   logic        ready;

   int vec = 0;
   int err = 0;

   logic [31:0] mdl [1024];
   logic [31:0] last;

   always #5 clk = ~clk;

   amem_port #(
      .AW(10),
      .DW(32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .aadr      (aadr),
      .arp       (arp),
      .awp       (awp),
      .l         (l),
      .amem      (amem),
      .amem_perr (amem_perr),
      .ready     (ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      foreach (mdl[i]) mdl[i] = '0;
      last = '0;
   endtask

   // One RUN cycle; called #1 after an edge, returns #1 after the next.
   task automatic cyc(input bit r, input bit w, input logic [9:0] a,
                      input logic [31:0] d, input string tag);
      arp = r; awp = w; aadr = a; l = d;
      @(posedge clk); #1;
      arp = 1'b0; awp = 1'b0;
      if (w) mdl[a] = d;
      if (r) last = mdl[a];
      chk({tag, " amem"}, amem, last);
      chk({tag, " perr"}, {31'b0, amem_perr}, 32'h0);
   endtask

   // Release reset and count edges until ready; optional INIT noise.
   task automatic sweep(input bit noise);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      model_reset();
      reset = 1'b1;
      while (!done && n < 2000) begin
         if (noise) begin
            arp  = 1'($urandom);
            awp  = 1'($urandom);
            aadr = 10'h020;
            l    = 32'hDEADBEEF;
         end
         @(posedge clk); #1;
         n++;
         if (ready) done = 1'b1;
         else if (n % 64 == 1) chk("init amem", amem, 32'h0);
      end
      arp = 1'b0; awp = 1'b0;
      chk("ready cycle", n, 1024);
   endtask

   task automatic reset_chk(input string tag);
      reset = 1'b0;
      #1;
      chk({tag, " amem"}, amem, 32'h0);
      chk({tag, " perr"}, {31'b0, amem_perr}, 32'h0);
      chk({tag, " ready"}, {31'b0, ready}, 32'h0);
      model_reset();
   endtask

   initial begin
      #2;
      chk("rst amem", amem, 32'h0);
      chk("rst perr", {31'b0, amem_perr}, 32'h0);
      chk("rst ready", {31'b0, ready}, 32'h0);
      @(posedge clk); #1;

      sweep(1'b1);
      cyc(1, 0, 10'h000, 0, "rd0");
      cyc(1, 0, 10'h1FF, 0, "rd511");
      cyc(1, 0, 10'h3FF, 0, "rd1023");
      cyc(1, 0, 10'h020, 0, "init ignored");
      chk("init ignored lit", amem, 32'h0);

      cyc(1, 0, 10'h1FF, 0, "pre");
      cyc(0, 1, 10'h005, 32'h12345678, "wr5");
      cyc(1, 0, 10'h005, 0, "byp5");
      chk("byp5 lit", amem, 32'h12345678);
      cyc(0, 0, 10'h000, 0, "hold");
      chk("hold lit", amem, 32'h12345678);

      cyc(1, 1, 10'h3FF, 32'hFFFFFFFF, "wt3ff");
      chk("wt3ff lit", amem, 32'hFFFFFFFF);
      cyc(0, 0, 10'h000, 0, "idle");
      cyc(1, 0, 10'h000, 0, "clr");
      cyc(1, 0, 10'h3FF, 0, "re3ff");
      chk("re3ff lit", amem, 32'hFFFFFFFF);

      cyc(0, 1, 10'h010, 32'hA5A5A5A5, "b2b0");
      cyc(0, 1, 10'h011, 32'h5A5A5A5A, "b2b1");
      cyc(1, 0, 10'h010, 0, "rd10");
      chk("rd10 lit", amem, 32'hA5A5A5A5);
      cyc(1, 0, 10'h011, 0, "rd11");
      chk("rd11 lit", amem, 32'h5A5A5A5A);

      for (int i = 0; i < 400; i++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 3) == 0) ? 10'($urandom) :
             10'($urandom_range(0, 15));
         cyc(1'($urandom), 1'($urandom), a, $urandom, "rand");
      end

      reset_chk("rst run");
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (300) @(posedge clk);
      #2;
      reset_chk("rst init");
      @(posedge clk); #1;
      sweep(1'b0);

      cyc(0, 1, 10'h033, 32'h11111111, "pw0");
      cyc(1, 1, 10'h02A, 32'hCAFEF00D, "pw1");
      chk("pw1 lit", amem, 32'hCAFEF00D);
      reset_chk("rst pw");
      @(posedge clk); #1;
      sweep(1'b0);
      cyc(1, 0, 10'h02A, 0, "pw lost");
      chk("pw lost lit", amem, 32'h0);
      cyc(1, 0, 10'h033, 0, "pw swept");

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/amem_port.md
AMEM_PORT -- requirements
Module: amem_port

Interface
REQ-001 Parameter AW, 10, A-memory address width (1024 words).
REQ-002 Parameter DW, 32, A-memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 aadr  input  AW  word address for read or write in the current cycle.
REQ-006 arp  input  1  A-memory read pulse; sample aadr for a read.
REQ-007 awp  input  1  A-memory write pulse; write l to aadr.
REQ-008 l  input  DW  write data.
REQ-009 amem  output  DW  registered read data.
REQ-010 amem_perr  output  1  registered parity error flag, aligned with amem.
REQ-011 ready  output  1  high when the clear sweep is done and requests are accepted.

Function
REQ-012 The array SHALL hold 2**AW words of DW+1 bits: data plus an odd-parity bit computed over the data at write time.
REQ-013 The FSM SHALL have two states: INIT and RUN.
REQ-014 In INIT, a sweep counter SHALL write zero data with correct parity to address 0, 1, ... 2**AW-1, one word per cycle, with ready=0.
REQ-015 The FSM SHALL move from INIT to RUN on the cycle after the write to address 2**AW-1.
REQ-016 ready SHALL be high in RUN; the first ready-high cycle SHALL be cycle 1024 after reset deassertion, counting the first edge as cycle 1.
REQ-017 In INIT, arp and awp SHALL be ignored; amem SHALL stay at 0 and no write SHALL be posted.
REQ-018 In RUN, an awp SHALL latch aadr and l into a single posted-write register (pw_valid, pw_adr, pw_dat).
REQ-019 A posted write SHALL commit to the array on the next edge.
REQ-020 Back-to-back awp SHALL commit each write in order, with one cycle of latency and no stall.
REQ-021 In RUN, an arp SHALL load amem and amem_perr on the next edge; read latency is 1 cycle.
REQ-022 amem and amem_perr SHALL hold their values in cycles without arp.
REQ-023 Read bypass: if arp and pw_valid are both set and aadr==pw_adr, amem SHALL be pw_dat and amem_perr SHALL be 0.
REQ-024 Otherwise, amem SHALL be the array data.
REQ-025 Simultaneous arp and awp to the same address SHALL return the new data l (write-through) with amem_perr=0.
REQ-026 Simultaneous arp and awp to different addresses SHALL read the old array/bypass contents and post the write.
REQ-027 amem_perr SHALL be 1 exactly when the stored parity bit does not give odd parity over the stored data.
REQ-028 Address arithmetic SHALL be unsigned AW-bit; the sweep counter SHALL stop at 2**AW-1 and not wrap.

Reset
REQ-029 When reset=0, asynchronously: amem=0, amem_perr=0, ready=0, state=INIT, sweep counter=0, pw_valid=0.
REQ-030 Array contents SHALL NOT be reset; they are defined only by the INIT sweep.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep from address 0 after deassertion.
REQ-032 A write posted but not committed when reset asserts SHALL be discarded.

Structure
REQ-033 Package amem_pkg SHALL hold AW, DW, the state typedef (INIT, RUN), and the constant INIT_LAST = 2**AW-1.
REQ-034 The storage SHALL be one sub-module, amem_ram: 2**AW x (DW+1), one synchronous write port and one synchronous read port, no reset.
REQ-035 amem_port SHALL contain the FSM, the sweep counter, the posted-write register, the bypass mux, and the parity generate/check logic.

Verification
REQ-036 Reset release, no requests -> ready rises on cycle 1024; reads of addresses 0, 511 and 1023 return amem=0, amem_perr=0.
REQ-037 RUN: awp aadr=0x005 l=0x12345678, next cycle arp aadr=0x005 -> amem=0x12345678 via bypass, one cycle later, amem_perr=0.
REQ-038 RUN: awp aadr=0x3FF l=0xFFFFFFFF and arp aadr=0x3FF in the same cycle -> amem=0xFFFFFFFF; a later read of 0x3FF still returns 0xFFFFFFFF.
REQ-039 RUN: awp 0x010=0xA5A5A5A5 then awp 0x011=0x5A5A5A5A back-to-back, then arp 0x010 and arp 0x011 -> 0xA5A5A5A5 then 0x5A5A5A5A.
REQ-040 arp/awp driven during INIT (awp 0x020=0xDEADBEEF) -> ignored; after ready, arp 0x020 -> 0x00000000.
REQ-041 reset pulsed low at cycle 300 of INIT and while a write is posted in RUN -> outputs go to 0 asynchronously; ready rises 1024 cycles after release; the posted address reads 0.
